// File: rtl/test_ram_arbiter_pkg.sv
// Shared encodings and test-RAM geometry for the test RAM arbiter slice.
package test_ram_arbiter_pkg;

   localparam int unsigned TR_ADDR_MSB_POS = 15;
   localparam int unsigned TR_DATA_MSB_POS = 7;
   localparam int unsigned DEFAULT_TIMEOUT = 15;
   localparam int unsigned CNT_W           = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   typedef enum logic {
      SEL_A = 1'b0,
      SEL_B = 1'b1
   } sel_e;

endpackage

// File: rtl/test_ram_arbiter_rr_pick.sv
// Combinational two-way round-robin pick; a tie goes to the port not granted last.
module test_ram_rr_pick
   import test_ram_arbiter_pkg::*;
(
   input  logic a_req_i,
   input  logic b_req_i,
   input  sel_e last_grant_i,
   output logic grant_valid_o,
   output sel_e grant_sel_o
);

   always_comb begin
      grant_valid_o = a_req_i | b_req_i;
      if (a_req_i && b_req_i) begin
         grant_sel_o = (last_grant_i == SEL_A) ? SEL_B : SEL_A;
      end else if (a_req_i) begin
         grant_sel_o = SEL_A;
      end else begin
         grant_sel_o = SEL_B;
      end
   end

endmodule

// File: rtl/test_ram_arbiter.sv
// Round-robin arbiter/sequencer sharing the block-RAM test memory between a CPU
// master (A) and a debug/loader master (B); every RAM-side output is registered.
module test_ram_arbiter
   import test_ram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = TR_ADDR_MSB_POS + 1,
   parameter int unsigned DATA_WIDTH = TR_DATA_MSB_POS + 1,
   parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_ack,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_ack,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  err,
   output logic                  ram_req_rdwr,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   input  logic                  ram_data_ready,
   output logic                  busy
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_e                state_q, state_d;
   sel_e                  last_grant_q, last_grant_d;
   sel_e                  gnt_q, gnt_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  ram_req_q, ram_req_d;
   logic                  ram_we_q, ram_we_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
   logic                  a_ack_q, a_ack_d, b_ack_q, b_ack_d, err_q, err_d;
   logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
   logic                  grant_valid;
   sel_e                  grant_sel;
   logic                  access_end;

   test_ram_rr_pick u_pick (
      .a_req_i       (a_req),
      .b_req_i       (b_req),
      .last_grant_i  (last_grant_q),
      .grant_valid_o (grant_valid),
      .grant_sel_o   (grant_sel)
   );

   // data_ready takes precedence over an expiring counter on the same cycle
   assign access_end = ram_data_ready || (cnt_q == TIMEOUT_C);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= SEL_B;
         gnt_q        <= SEL_A;
         cnt_q        <= '0;
         ram_req_q    <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_data_q   <= '0;
         a_ack_q      <= 1'b0;
         b_ack_q      <= 1'b0;
         err_q        <= 1'b0;
         a_rdata_q    <= '0;
         b_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         gnt_q        <= gnt_d;
         cnt_q        <= cnt_d;
         ram_req_q    <= ram_req_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_data_q   <= ram_data_d;
         a_ack_q      <= a_ack_d;
         b_ack_q      <= b_ack_d;
         err_q        <= err_d;
         a_rdata_q    <= a_rdata_d;
         b_rdata_q    <= b_rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (grant_valid) state_d = ST_ACCESS;
         ST_ACCESS: if (access_end)  state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      last_grant_d = last_grant_q;
      gnt_d        = gnt_q;
      cnt_d        = cnt_q;
      ram_req_d    = ram_req_q;
      ram_we_d     = ram_we_q;
      ram_addr_d   = ram_addr_q;
      ram_data_d   = ram_data_q;
      a_ack_d      = 1'b0;
      b_ack_d      = 1'b0;
      err_d        = 1'b0;
      a_rdata_d    = a_rdata_q;
      b_rdata_d    = b_rdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (grant_valid) begin
               ram_req_d    = 1'b1;
               ram_we_d     = (grant_sel == SEL_A) ? a_we    : b_we;
               ram_addr_d   = (grant_sel == SEL_A) ? a_addr  : b_addr;
               ram_data_d   = (grant_sel == SEL_A) ? a_wdata : b_wdata;
               last_grant_d = grant_sel;
               gnt_d        = grant_sel;
               cnt_d        = '0;
            end
         end
         ST_ACCESS: begin
            if (access_end) begin
               ram_req_d = 1'b0;
               ram_we_d  = 1'b0;
               err_d     = !ram_data_ready;
               if (gnt_q == SEL_A) a_ack_d = 1'b1;
               else                b_ack_d = 1'b1;
               if (ram_data_ready && !ram_we_q) begin
                  if (gnt_q == SEL_A) a_rdata_d = ram_data_out;
                  else                b_rdata_d = ram_data_out;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign a_ack        = a_ack_q;
   assign b_ack        = b_ack_q;
   assign err          = err_q;
   assign a_rdata      = a_rdata_q;
   assign b_rdata      = b_rdata_q;
   assign ram_req_rdwr = ram_req_q;
   assign ram_we       = ram_we_q;
   assign ram_addr     = ram_addr_q;
   assign ram_data_in  = ram_data_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_test_ram_arbiter.sv
// Scoreboard bench for test_ram_arbiter with a behavioural two-cycle block-RAM model.
module tb_test_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_req, a_we, b_req, b_we;
   logic [15:0] a_addr, b_addr;
   logic [7:0]  a_wdata, b_wdata;
   logic        a_ack, b_ack, err, busy;
   logic [7:0]  a_rdata, b_rdata;
   logic        ram_req_rdwr, ram_we, ram_data_ready;
   logic [15:0] ram_addr;
   logic [7:0]  ram_data_in, ram_data_out;

   logic        ram_stall = 1'b0;
   logic [7:0]  mem [0:255];
   logic [1:0]  rcnt;
   int          cyc = 0;
   int          gap = 0;
   int          last_gap = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   typedef struct {
      bit         port;
      logic [7:0] rdata;
      bit         err;
      int         cyc;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   test_ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .err(err),
      .ram_req_rdwr(ram_req_rdwr), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
      .ram_data_ready(ram_data_ready), .busy(busy)
   );

   // RAM model: data_ready rises on the second edge that sees req_rdwr high
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         mem[8'h10]     <= 8'hA5;
         mem[8'h11]     <= 8'h5A;
         mem[8'h30]     <= 8'hC3;
         rcnt           <= 2'd0;
         ram_data_ready <= 1'b0;
         ram_data_out   <= 8'h00;
      end else if (ram_stall) begin
         rcnt           <= 2'd0;
         ram_data_ready <= 1'b0;
         ram_data_out   <= 8'hEE;
      end else if (ram_req_rdwr) begin
         if (rcnt < 2'd2) rcnt <= rcnt + 2'd1;
         if (rcnt == 2'd1) begin
            ram_data_ready <= 1'b1;
            if (ram_we) mem[ram_addr[7:0]] <= ram_data_in;
            ram_data_out <= ram_we ? ram_data_in : mem[ram_addr[7:0]];
         end
      end else begin
         rcnt           <= 2'd0;
         ram_data_ready <= 1'b0;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ram_req_rdwr) begin
         if (gap != 0) last_gap <= gap;
         gap <= 0;
      end else begin
         gap <= gap + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && (a_ack || b_ack)) begin
         if (sb.size() == 0) begin
            check("unexpected_ack", 32'({a_ack, b_ack}), 32'h0);
         end else begin
            e = sb.pop_front();
            check("ack_port", 32'({a_ack, b_ack}), e.port ? 32'h1 : 32'h2);
            check("ack_rdata", 32'(e.port ? b_rdata : a_rdata), 32'(e.rdata));
            check("ack_err", 32'(err), 32'(e.err));
            check("ack_cycle", 32'(cyc), 32'(e.cyc));
         end
      end else if (rst_n && err) begin
         check("stray_err", 32'(err), 32'h0);
      end
   end

   task automatic start_req(input bit port, input bit we, input logic [15:0] addr,
                            input logic [7:0] wd, input logic [7:0] exp_rd,
                            input bit exp_err, input int lat);
      exp_t e;
      e.port  = port;
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.cyc   = cyc + lat;
      sb.push_back(e);
      if (!port) begin
         a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
      end else begin
         b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
      end
   endtask

   task automatic wait_ack(input bit port);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (port ? b_ack : a_ack) seen = 1'b1;
      end
      check(port ? "b_ack_seen" : "a_ack_seen", 32'(seen), 32'h1);
      if (!port) a_req = 1'b0;
      else       b_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int na, nb;
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_a_ack", 32'(a_ack), 32'h0);
      check("rst_b_ack", 32'(b_ack), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_a_rdata", 32'(a_rdata), 32'h0);
      check("rst_b_rdata", 32'(b_rdata), 32'h0);
      check("rst_ram_req", 32'(ram_req_rdwr), 32'h0);
      check("rst_ram_we", 32'(ram_we), 32'h0);
      check("rst_ram_addr", 32'(ram_addr), 32'h0);
      check("rst_ram_din", 32'(ram_data_in), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // single read by A
      start_req(1'b0, 1'b0, 16'h0010, 8'h00, 8'hA5, 1'b0, 4);
      @(negedge clk);
      check("grant_busy", 32'(busy), 32'h1);
      check("grant_ram_req", 32'(ram_req_rdwr), 32'h1);
      check("grant_ram_addr", 32'(ram_addr), 32'h0010);
      wait_ack(1'b0);
      @(negedge clk);

      // B write then B read
      start_req(1'b1, 1'b1, 16'h0020, 8'h3C, 8'h00, 1'b0, 4);
      wait_ack(1'b1);
      @(negedge clk);
      start_req(1'b1, 1'b0, 16'h0020, 8'h00, 8'h3C, 1'b0, 4);
      wait_ack(1'b1);
      check("req_gap_ge2", 32'(last_gap >= 2), 32'h1);
      @(negedge clk);

      // contention: both held, grants alternate A,B,A,B every 5 cycles
      start_req(1'b0, 1'b0, 16'h0010, 8'h00, 8'hA5, 1'b0, 4);
      start_req(1'b1, 1'b0, 16'h0030, 8'h00, 8'hC3, 1'b0, 9);
      start_req(1'b0, 1'b0, 16'h0010, 8'h00, 8'hA5, 1'b0, 14);
      start_req(1'b1, 1'b0, 16'h0030, 8'h00, 8'hC3, 1'b0, 19);
      na = 0;
      nb = 0;
      for (int i = 0; i < 60 && (na < 2 || nb < 2); i++) begin
         @(negedge clk);
         if (a_ack) begin na++; if (na == 2) a_req = 1'b0; end
         if (b_ack) begin nb++; if (nb == 2) b_req = 1'b0; end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      check("contention_a_acks", 32'(na), 32'h2);
      check("contention_b_acks", 32'(nb), 32'h2);
      @(negedge clk);

      // request inputs changed during ACCESS must be ignored
      start_req(1'b0, 1'b0, 16'h0010, 8'h00, 8'hA5, 1'b0, 4);
      @(negedge clk);
      a_addr = 16'h0011;
      @(negedge clk);
      check("ram_addr_held", 32'(ram_addr), 32'h0010);
      check("ram_req_held", 32'(ram_req_rdwr), 32'h1);
      wait_ack(1'b0);
      @(negedge clk);

      // timeout with RAM never ready: error ack, rdata unchanged
      ram_stall = 1'b1;
      start_req(1'b0, 1'b0, 16'h0040, 8'h00, 8'hA5, 1'b1, 17);
      wait_ack(1'b0);
      @(negedge clk);
      check("timeout_idle_busy", 32'(busy), 32'h0);
      check("timeout_ram_req", 32'(ram_req_rdwr), 32'h0);
      ram_stall = 1'b0;
      @(negedge clk);

      // reset one cycle after grant of a write
      a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0050; a_wdata = 8'h77;
      @(negedge clk);
      check("pre_rst_ram_req", 32'(ram_req_rdwr), 32'h1);
      check("pre_rst_ram_we", 32'(ram_we), 32'h1);
      @(negedge clk);
      rst_n = 1'b0;
      a_req = 1'b0; a_we = 1'b0;
      #1;
      check("mid_rst_ram_req", 32'(ram_req_rdwr), 32'h0);
      check("mid_rst_ram_we", 32'(ram_we), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_a_ack", 32'(a_ack), 32'h0);
      @(negedge clk);
      check("mid_rst_a_rdata", 32'(a_rdata), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      start_req(1'b0, 1'b0, 16'h0010, 8'h00, 8'hA5, 1'b0, 4);
      wait_ack(1'b0);

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
